// File: rtl/cart_rom_arbiter.sv
`timescale 1ns/1ps
// cart_rom_arbiter: shares one cartridge ROM read bus between the splash
// generator (port 0) and the game/loader path (port 1). One read in flight,
// round-robin or fixed-priority grant, synchronized rom_bsy, sticky timeout.
module cart_rom_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter bit          PRIO_FIXED  = 1'b0
) (
    input  logic              clk_8m,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_rd,
    output logic [7:0]        req0_data,
    output logic              req0_bsy,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_rd,
    output logic [7:0]        req1_data,
    output logic              req1_bsy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_data,
    input  logic              rom_bsy,
    output logic              gnt,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t              state, state_d;
    logic [SYNC_STAGES-1:0] bsy_sync;
    logic                bsy_s;
    logic                rd0_q, rd1_q;
    logic                rise0, rise1;
    logic                pend0, pend1;
    logic [ADDR_W-1:0]   addr0_q, addr1_q;
    logic                rr_ptr;
    logic                pick;
    logic                grant;
    logic                timeout_hit;
    logic [CNT_W-1:0]    cnt;

    assign bsy_s    = bsy_sync[SYNC_STAGES-1];
    assign rise0    = req0_rd & ~rd0_q;
    assign rise1    = req1_rd & ~rd1_q;
    assign req0_bsy = pend0;
    assign req1_bsy = pend1;

    // Synchronize the asynchronous ROM busy line.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            bsy_sync <= '0;
        end else begin
            bsy_sync[0] <= rom_bsy;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                bsy_sync[i] <= bsy_sync[i-1];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Arbitration choice and next-state decode.
    always_comb begin
        state_d     = state;
        grant       = 1'b0;
        timeout_hit = 1'b0;
        if (PRIO_FIXED) begin
            pick = pend0 ? 1'b0 : 1'b1;
        end else begin
            pick = (rr_ptr ? pend1 : pend0) ? rr_ptr : ~rr_ptr;
        end
        case (state)
            S_IDLE: begin
                if (pend0 || pend1) begin
                    grant   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bsy_s) begin
                    state_d = S_WAIT;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_WAIT: begin
                if (!bsy_s) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request edge capture, pending flags and per-port read data.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            rd0_q     <= 1'b0;
            rd1_q     <= 1'b0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
            addr0_q   <= '0;
            addr1_q   <= '0;
            req0_data <= '0;
            req1_data <= '0;
        end else begin
            rd0_q <= req0_rd;
            rd1_q <= req1_rd;
            // A rising edge while already pending is a protocol violation and is dropped.
            if (state == S_DONE && !gnt) begin
                pend0     <= 1'b0;
                req0_data <= rom_data;
            end else if (rise0 && !pend0) begin
                pend0   <= 1'b1;
                addr0_q <= req0_addr;
            end
            if (state == S_DONE && gnt) begin
                pend1     <= 1'b0;
                req1_data <= rom_data;
            end else if (rise1 && !pend1) begin
                pend1   <= 1'b1;
                addr1_q <= req1_addr;
            end
        end
    end

    // ROM bus drive, grant record, ack timer, RR pointer and error flag.
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr    <= '0;
            rom_rd      <= 1'b0;
            gnt         <= 1'b0;
            cnt         <= '0;
            rr_ptr      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (grant) begin
                rom_addr <= pick ? addr1_q : addr0_q;
                rom_rd   <= 1'b1;
                gnt      <= pick;
                cnt      <= '0;
            end else if (state == S_ISSUE) begin
                if (bsy_s || timeout_hit) begin
                    rom_rd <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == S_DONE) begin
                rr_ptr <= ~gnt;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cart_rom_arbiter.sv
`timescale 1ns/1ps
// Directed self-checking bench for cart_rom_arbiter with a behavioural ROM.
module tb_cart_rom_arbiter;

    logic        clk_8m = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] req0_addr = '0, req1_addr = '0;
    logic        req0_rd = 1'b0, req1_rd = 1'b0;
    logic [7:0]  req0_data, req1_data;
    logic        req0_bsy, req1_bsy;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;
    logic        rom_bsy;
    logic        gnt, timeout_err;
    logic        err_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    // ROM model controls (written only by the main sequence)
    logic rom_ack_en = 1'b1;
    int   bsy_cycles = 10;

    cart_rom_arbiter #(
        .ADDR_W(16), .SYNC_STAGES(2), .ACK_TIMEOUT(64), .PRIO_FIXED(1'b0)
    ) dut (
        .clk_8m(clk_8m), .rst_n(rst_n),
        .req0_addr(req0_addr), .req0_rd(req0_rd), .req0_data(req0_data), .req0_bsy(req0_bsy),
        .req1_addr(req1_addr), .req1_rd(req1_rd), .req1_data(req1_data), .req1_bsy(req1_bsy),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data), .rom_bsy(rom_bsy),
        .gnt(gnt), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk_8m = ~clk_8m;

    function automatic logic [7:0] rom_value(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hFB;
    endfunction

    // Cycle counter
    int cyc = 0;
    always @(posedge clk_8m) cyc <= cyc + 1;

    // Bus monitor, sampled mid-cycle
    int          rd_rises = 0, rd_high = 0, b1_high = 0, b0_fall_cyc = 0;
    logic        prev_rd = 1'b0, prev_b0 = 1'b0;
    logic        g_port[$];
    logic [15:0] g_addr[$];
    int          g_cyc[$];
    always @(negedge clk_8m) begin
        if (rom_rd) rd_high++;
        if (req1_bsy) b1_high++;
        if (rom_rd && !prev_rd) begin
            rd_rises++;
            g_port.push_back(gnt);
            g_addr.push_back(rom_addr);
            g_cyc.push_back(cyc);
        end
        if (!req0_bsy && prev_b0) b0_fall_cyc = cyc;
        prev_rd = rom_rd;
        prev_b0 = req0_bsy;
    end

    // ROM: on rom_rd raise busy for bsy_cycles, then present data as busy falls
    initial begin
        logic [15:0] a;
        rom_bsy  = 1'b0;
        rom_data = 8'h00;
        forever begin
            @(posedge clk_8m);
            if (rom_rd && rom_ack_en && !rom_bsy) begin
                a = rom_addr;
                #1 rom_bsy = 1'b1;
                repeat (bsy_cycles) @(posedge clk_8m);
                #1;
                rom_data = rom_value(a);
                rom_bsy  = 1'b0;
            end
        end
    end

    task automatic do_reset;
        rst_n      = 1'b0;
        req0_rd    = 1'b0;
        req1_rd    = 1'b0;
        err_clr    = 1'b0;
        rom_ack_en = 1'b1;
        repeat (3) @(negedge clk_8m);
        rst_n = 1'b1;
        @(negedge clk_8m);
    endtask

    task automatic wait_bsy_low(input int p, input int limit);
        int n = 0;
        while (((p == 0) ? req0_bsy : req1_bsy) && n < limit) begin
            @(negedge clk_8m);
            n++;
        end
        checks++;
        if (((p == 0) ? req0_bsy : req1_bsy) !== 1'b0) begin
            errors++;
            $display("FAIL bsy_timeout port%0d: bsy=1 after %0d cycles, required 0", p, limit);
        end
    endtask

    task automatic drive_port(input int p, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_8m);
            if (p == 0) begin req0_addr = base + 16'(k); req0_rd = 1'b1; end
            else        begin req1_addr = base + 16'(k); req1_rd = 1'b1; end
            @(negedge clk_8m);
            if (p == 0) req0_rd = 1'b0; else req1_rd = 1'b0;
            wait_bsy_low(p, 300);
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (rom_rd !== 1'b0)      begin errors++; $display("FAIL rst_rom_rd: got %b, required 0", rom_rd); end
        checks++; if (rom_addr !== 16'h0)   begin errors++; $display("FAIL rst_rom_addr: got %h, required 0000", rom_addr); end
        checks++; if ({req0_bsy, req1_bsy} !== 2'b00) begin errors++; $display("FAIL rst_bsy: got %b, required 00", {req0_bsy, req1_bsy}); end
        checks++; if ({req0_data, req1_data} !== 16'h0) begin errors++; $display("FAIL rst_data: got %h, required 0000", {req0_data, req1_data}); end
        checks++; if ({gnt, timeout_err} !== 2'b00) begin errors++; $display("FAIL rst_gnt_err: got %b, required 00", {gnt, timeout_err}); end
    endtask

    task automatic test_single;
        int b1_base;
        do_reset();
        b1_base = b1_high;
        @(negedge clk_8m);
        req0_addr = 16'h0134;
        req0_rd   = 1'b1;
        @(negedge clk_8m);
        checks++; if ({req0_bsy, rom_rd} !== 2'b10) begin errors++; $display("FAIL single_capture: bsy,rd=%b, required 10", {req0_bsy, rom_rd}); end
        @(negedge clk_8m);
        checks++; if (rom_rd !== 1'b1) begin errors++; $display("FAIL single_rd_latency: got %b, required 1", rom_rd); end
        checks++; if (rom_addr !== 16'h0134) begin errors++; $display("FAIL single_addr: got %h, required 0134", rom_addr); end
        req0_rd = 1'b0;
        wait_bsy_low(0, 100);
        checks++; if (req0_data !== 8'hCE) begin errors++; $display("FAIL single_data: got %h, required ce", req0_data); end
        checks++; if (b1_high - b1_base !== 0) begin errors++; $display("FAIL single_req1_bsy: high %0d cycles, required 0", b1_high - b1_base); end
        checks++; if ({gnt, timeout_err} !== 2'b00) begin errors++; $display("FAIL single_gnt_err: got %b, required 00", {gnt, timeout_err}); end
    endtask

    task automatic test_both;
        int g0;
        do_reset();
        g0 = g_port.size();
        @(negedge clk_8m);
        req0_addr = 16'h0100; req1_addr = 16'h0200;
        req0_rd = 1'b1; req1_rd = 1'b1;
        @(negedge clk_8m);
        req0_rd = 1'b0; req1_rd = 1'b0;
        wait_bsy_low(0, 200);
        wait_bsy_low(1, 200);
        checks++; if (g_port.size() - g0 !== 2) begin errors++; $display("FAIL both_count: %0d grants, required 2", g_port.size() - g0); end
        else begin
            checks++; if ({g_port[g0], g_addr[g0]} !== {1'b0, 16'h0100}) begin errors++; $display("FAIL both_first: port %b addr %h, required 0/0100", g_port[g0], g_addr[g0]); end
            checks++; if ({g_port[g0+1], g_addr[g0+1]} !== {1'b1, 16'h0200}) begin errors++; $display("FAIL both_second: port %b addr %h, required 1/0200", g_port[g0+1], g_addr[g0+1]); end
            checks++; if (g_cyc[g0+1] - b0_fall_cyc !== 1) begin errors++; $display("FAIL both_gap: %0d cycles, required 1", g_cyc[g0+1] - b0_fall_cyc); end
        end
        checks++; if ({req0_data, req1_data} !== 16'hFAF9) begin errors++; $display("FAIL both_data: got %h, required faf9", {req0_data, req1_data}); end
        // pointer returned to port 0: a second simultaneous pair serves port 0 first
        @(negedge clk_8m);
        req0_rd = 1'b1; req1_rd = 1'b1;
        @(negedge clk_8m);
        req0_rd = 1'b0; req1_rd = 1'b0;
        wait_bsy_low(0, 200);
        wait_bsy_low(1, 200);
        checks++; if (g_port.size() - g0 !== 4) begin errors++; $display("FAIL both_count2: %0d grants, required 4", g_port.size() - g0); end
        else begin
            checks++; if (g_port[g0+2] !== 1'b0) begin errors++; $display("FAIL both_ptr: first port %b, required 0", g_port[g0+2]); end
        end
    endtask

    task automatic test_alternate;
        int g0;
        do_reset();
        g0 = g_port.size();
        fork
            drive_port(0, 3, 16'h0300);
            drive_port(1, 3, 16'h0400);
        join
        checks++; if (g_port.size() - g0 !== 6) begin errors++; $display("FAIL alt_count: %0d grants, required 6", g_port.size() - g0); end
        else begin
            for (int i = 0; i < 6; i++) begin
                logic        ep;
                logic [15:0] ea;
                ep = logic'(i % 2);
                ea = (ep ? 16'h0400 : 16'h0300) + 16'(i / 2);
                checks++;
                if ({g_port[g0+i], g_addr[g0+i]} !== {ep, ea}) begin
                    errors++;
                    $display("FAIL alt_grant%0d: port %b addr %h, required %b/%h", i, g_port[g0+i], g_addr[g0+i], ep, ea);
                end
            end
        end
        checks++; if ({req0_data, req1_data} !== {rom_value(16'h0302), rom_value(16'h0402)}) begin errors++; $display("FAIL alt_data: got %h, required %h", {req0_data, req1_data}, {rom_value(16'h0302), rom_value(16'h0402)}); end
    endtask

    task automatic test_timeout;
        int hi0, n;
        do_reset();
        rom_ack_en = 1'b0;
        hi0 = rd_high;
        @(negedge clk_8m);
        req0_addr = 16'h0050; req0_rd = 1'b1;
        @(negedge clk_8m);
        req0_rd = 1'b0;
        wait_bsy_low(0, 200);
        checks++; if (rd_high - hi0 !== 64) begin errors++; $display("FAIL to_rd_cycles: %0d, required 64", rd_high - hi0); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag_set: got %b, required 1", timeout_err); end
        repeat (5) @(negedge clk_8m);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag_sticky: got %b, required 1", timeout_err); end
        err_clr = 1'b1;
        @(negedge clk_8m);
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_flag_clr: got %b, required 0", timeout_err); end
        // err_clr held across a second timeout: the set must win on that edge
        err_clr = 1'b1;
        req0_rd = 1'b1;
        @(negedge clk_8m);
        req0_rd = 1'b0;
        n = 0;
        while (!rom_rd && n < 10) begin @(negedge clk_8m); n++; end
        n = 0;
        while (rom_rd && n < 200) begin @(negedge clk_8m); n++; end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set_wins: got %b, required 1", timeout_err); end
        @(negedge clk_8m);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clr_after: got %b, required 0", timeout_err); end
        err_clr = 1'b0;
        wait_bsy_low(0, 50);
        rom_ack_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int n, r0;
        do_reset();
        @(negedge clk_8m);
        req0_addr = 16'h0060; req0_rd = 1'b1;
        @(negedge clk_8m);
        req0_rd = 1'b0;
        n = 0;
        while (!(rom_bsy && !rom_rd && req0_bsy) && n < 100) begin @(negedge clk_8m); n++; end
        checks++; if (rom_addr !== 16'h0060) begin errors++; $display("FAIL mid_reach_wait: rom_addr %h, required 0060", rom_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({req0_bsy, req1_bsy, rom_rd, gnt, timeout_err} !== 5'b0) begin errors++; $display("FAIL mid_rst_ctrl: got %b, required 00000", {req0_bsy, req1_bsy, rom_rd, gnt, timeout_err}); end
        checks++; if ({rom_addr, req0_data, req1_data} !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %h, required 0", {rom_addr, req0_data, req1_data}); end
        @(negedge clk_8m);
        rst_n = 1'b1;
        n = 0;
        while (rom_bsy && n < 50) begin @(negedge clk_8m); n++; end
        r0 = rd_rises;
        @(negedge clk_8m);
        req1_addr = 16'h00A1; req1_rd = 1'b1;
        @(negedge clk_8m);
        req1_rd = 1'b0;
        wait_bsy_low(1, 200);
        checks++; if (req1_data !== 8'h5A) begin errors++; $display("FAIL mid_after_data: got %h, required 5a", req1_data); end
        checks++; if ({gnt, req0_bsy} !== 2'b10) begin errors++; $display("FAIL mid_after_gnt: gnt,bsy0=%b, required 10", {gnt, req0_bsy}); end
        checks++; if (rd_rises - r0 !== 1) begin errors++; $display("FAIL mid_no_replay: %0d reads, required 1", rd_rises - r0); end
    endtask

    task automatic test_held;
        int r0;
        do_reset();
        r0 = rd_rises;
        @(negedge clk_8m);
        req0_addr = 16'h0070; req0_rd = 1'b1;
        repeat (100) @(negedge clk_8m);
        req0_rd = 1'b0;
        @(negedge clk_8m);
        checks++; if (rd_rises - r0 !== 1) begin errors++; $display("FAIL held_reads: %0d, required 1", rd_rises - r0); end
        checks++; if ({req0_bsy, req0_data} !== {1'b0, rom_value(16'h0070)}) begin errors++; $display("FAIL held_done: got %h, required %h", {req0_bsy, req0_data}, {1'b0, rom_value(16'h0070)}); end
        r0 = rd_rises;
        req0_addr = 16'h0080; req0_rd = 1'b1;
        @(negedge clk_8m);
        req0_rd = 1'b0;
        req0_addr = 16'h0090;
        @(negedge clk_8m);
        req0_rd = 1'b1;
        @(negedge clk_8m);
        req0_rd = 1'b0;
        wait_bsy_low(0, 200);
        repeat (20) @(negedge clk_8m);
        checks++; if (rd_rises - r0 !== 1) begin errors++; $display("FAIL busy_edge_reads: %0d, required 1", rd_rises - r0); end
        checks++; if ({req0_bsy, rom_addr} !== {1'b0, 16'h0080}) begin errors++; $display("FAIL busy_edge_addr: got %h, required 0080", {req0_bsy, rom_addr}); end
        checks++; if (req0_data !== rom_value(16'h0080)) begin errors++; $display("FAIL busy_edge_data: got %h, required %h", req0_data, rom_value(16'h0080)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_alternate();
        test_timeout();
        test_reset_mid();
        test_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
